// File: rtl/instr_sequencer_if.sv
// Instruction-fetch and data-memory handshake bundle between the sequencer
// (master) and the memory subsystem (slave).
interface instr_sequencer_if #(
  parameter int PC_W = 8
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [7:0]      imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the 8-bit core:
// owns pc and ir, sequences strobes from decoder flags, supports halt.
module instr_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.master bus,
  output logic [7:0]        ir_o,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              reg_write_i,
  input  logic              pc_load_i,
  input  logic [PC_W-1:0]   pc_load_val_i,
  output logic              alu_en_o,
  output logic              rf_we_o,
  input  logic              halt_req_i,
  output logic              halted_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [15:0]       retired_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc_q;
  logic [7:0]      ir_q;
  logic [15:0]     retired_q;
  logic            run_s;

  // Sequencer state, program counter, instruction register and retire count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      ir_q      <= 8'h00;
      retired_q <= 16'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ready) begin
            ir_q    <= bus.imem_rdata;
            state_q <= S_DECODE;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          next_pc_q <= pc_load_i ? pc_load_val_i : pc_q + PC_W'(1);
          state_q   <= (mem_read_i | mem_write_i) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            state_q <= S_WB;
          end else begin
            state_q <= S_MEM;
          end
        end
        S_WB: begin
          pc_q      <= next_pc_q;
          retired_q <= retired_q + 16'd1;
          state_q   <= halt_req_i ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          if (!halt_req_i) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_HALT;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs decode the state register only; reset masks everything except pc/state.
  assign run_s = ~reset;

  assign bus.imem_req  = run_s & (state_q == S_FETCH);
  assign bus.imem_addr = run_s ? pc_q : '0;
  assign bus.dmem_req  = run_s & (state_q == S_MEM);
  assign bus.dmem_we   = run_s & (state_q == S_MEM) & mem_write_i;
  assign alu_en_o      = run_s & (state_q == S_EXEC);
  assign rf_we_o       = run_s & (state_q == S_WB) & reg_write_i;
  assign halted_o      = run_s & (state_q == S_HALT);
  assign ir_o          = run_s ? ir_q : 8'h00;
  assign retired_o     = run_s ? retired_q : 16'd0;
  assign pc_o          = pc_q;
  assign state_o       = state_q;

endmodule
